// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the program/data memory arbiter.
// Build option: MEM_ARB_CONFLICT_CNT_EN enables the request conflict counter in mem_arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Priority select between fetch and data ports with a starvation counter
// that hands the memory to fetch after MAX_WAIT consecutive data wins.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic notrst,
  input  logic if_req,
  input  logic d_req,
  input  logic free,
  output logic sel_if,
  output logic sel_d
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] wait_q, wait_d;
  logic          starved;

  // Data normally wins; a fetch that has been passed over MAX_WAIT times takes the slot.
  always_comb begin
    starved = (wait_q == WW'(MAX_WAIT));
    sel_d   = free & d_req & ~(if_req & starved);
    sel_if  = free & if_req & ~sel_d;
    wait_d  = wait_q;
    if (!if_req || sel_if) begin
      wait_d = '0;
    end else if (sel_d && !starved) begin
      wait_d = wait_q + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge notrst) begin
    if (!notrst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port program/data memory between instruction fetch and data accesses.
// Build option: define MEM_ARB_CONFLICT_CNT_EN to count free cycles with both ports requesting.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              notrst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  localparam int BW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

  arb_state_e    state_q, state_d;
  logic [BW-1:0] busy_q, busy_d;
  owner_e        owner_q, owner_d;
  logic          last_cycle, free, sel_if, sel_d, issue;

  // The last latency cycle both completes the current access and may issue the next one.
  assign last_cycle = (state_q == ARB_BUSY) && (busy_q == BW'(1));
  assign free       = notrst && ((state_q == ARB_IDLE) || last_cycle);
  assign issue      = sel_if | sel_d;

  mem_arb_prio #(
    .MAX_WAIT(MAX_WAIT)
  ) u_prio (
    .clk   (clk),
    .notrst(notrst),
    .if_req(if_req),
    .d_req (d_req),
    .free  (free),
    .sel_if(sel_if),
    .sel_d (sel_d)
  );

  always_comb begin
    if_gnt    = sel_if;
    d_gnt     = sel_d;
    mem_en    = issue;
    mem_we    = sel_d & d_we;
    mem_addr  = sel_d ? d_addr : (sel_if ? if_addr : '0);
    mem_wdata = sel_d ? d_wdata : '0;
    if_valid  = last_cycle && (owner_q == OWN_IF);
    d_valid   = last_cycle && (owner_q == OWN_D);
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    if (issue) begin
      state_d = ARB_BUSY;
      busy_d  = BW'(MEM_LAT);
      owner_d = sel_d ? OWN_D : OWN_IF;
    end else if (state_q == ARB_BUSY) begin
      if (last_cycle) begin
        state_d = ARB_IDLE;
        busy_d  = '0;
      end else begin
        busy_d = busy_q - BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge notrst) begin
    if (!notrst) begin
      state_q <= ARB_IDLE;
      busy_q  <= '0;
      owner_q <= OWN_IF;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

`ifdef MEM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (free && if_req && d_req && (conflict_q != 16'hffff)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge notrst) begin
    if (!notrst) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a MEM_LAT=1 and a MEM_LAT=3 instance, each with a behavioural memory.
// Build option: MEM_ARB_CONFLICT_CNT_EN selects the expected conflict counter behaviour.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 3;

  logic        clk;
  logic        notrst;

  logic        if_req, if_gnt, if_valid, d_req, d_we, d_gnt, d_valid, mem_en, mem_we;
  logic [7:0]  if_addr, d_addr, mem_addr;
  logic [15:0] d_wdata, mem_wdata, mem_rdata, conflict_cnt;

  logic        if_req3, if_gnt3, if_valid3, d_req3, d_we3, d_gnt3, d_valid3, mem_en3, mem_we3;
  logic [7:0]  if_addr3, d_addr3, mem_addr3;
  logic [15:0] d_wdata3, mem_wdata3, mem_rdata3, conflict_cnt3;

  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  logic [15:0] ref_mem [256];
  logic [15:0] p0_3, p1_3;
  bit          m1_ready = 1'b0;
  bit          m3_ready = 1'b0;

  int tests_run;
  int tests_failed;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(1), .MAX_WAIT(MAX_WAIT)) u_dut (
    .clk(clk), .notrst(notrst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(3), .MAX_WAIT(MAX_WAIT)) u_dut3 (
    .clk(clk), .notrst(notrst),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_valid(if_valid3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_valid(d_valid3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .conflict_cnt(conflict_cnt3)
  );

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return 16'h1000 + 16'({8'h00, a} * 16'd3);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle memory for the MEM_LAT=1 instance; contents load on the first edge (held in reset).
  always @(posedge clk) begin
    if (!m1_ready) begin
      for (int i = 0; i < 256; i++) mem1[i] <= init_val(8'(i));
      m1_ready  <= 1'b1;
      mem_rdata <= 16'h0000;
    end else if (mem_en) begin
      if (mem_we) mem1[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem1[mem_addr];
    end
  end

  // Three-stage read pipeline for the MEM_LAT=3 instance (read-only usage).
  always @(posedge clk) begin
    if (!m3_ready) begin
      for (int i = 0; i < 256; i++) mem3[i] <= init_val(8'(i));
      m3_ready   <= 1'b1;
      p0_3       <= 16'h0000;
      p1_3       <= 16'h0000;
      mem_rdata3 <= 16'h0000;
    end else begin
      p0_3       <= mem3[mem_addr3];
      p1_3       <= p0_3;
      mem_rdata3 <= p1_3;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_req = 1'b0; d_req = 1'b0; if_req3 = 1'b0; d_req3 = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    notrst = 1'b0;
    if_req = 1'b1; if_addr = 8'haa; d_req = 1'b1; d_we = 1'b1; d_addr = 8'hff; d_wdata = 16'hffff;
    if_req3 = 1'b1; if_addr3 = 8'haa; d_req3 = 1'b1; d_we3 = 1'b1; d_addr3 = 8'hff; d_wdata3 = 16'hffff;
    @(negedge clk);
    tests_run++;
    if ({if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt} !== 46'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs_lat1: got %h expected 0",
               {if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt});
    end
    tests_run++;
    if ({if_gnt3, if_valid3, d_gnt3, d_valid3, mem_en3, mem_we3, mem_addr3, mem_wdata3, conflict_cnt3} !== 46'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs_lat3: got %h expected 0",
               {if_gnt3, if_valid3, d_gnt3, d_valid3, mem_en3, mem_we3, mem_addr3, mem_wdata3, conflict_cnt3});
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; if_req3 = 1'b0; d_req3 = 1'b0; d_we3 = 1'b0;
    step();
    notrst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({if_gnt, if_valid, d_gnt, d_valid, mem_en} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_idle: got %b expected 00000", {if_gnt, if_valid, d_gnt, d_valid, mem_en});
    end
    step();
  endtask

  task automatic test_conflict();
    logic [15:0] exp_cnt;
`ifdef MEM_ARB_CONFLICT_CNT_EN
    exp_cnt = 16'd5;
`else
    exp_cnt = 16'd0;
`endif
    if_req = 1'b1; if_addr = 8'h01; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h02;
    repeat (5) step();
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (conflict_cnt !== exp_cnt) begin
      tests_failed++;
      $display("[TB] FAIL conflict_cnt: got %0d expected %0d", conflict_cnt, exp_cnt);
    end
    tests_run++;
    if (conflict_cnt3 !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL conflict_cnt_quiet: got %0d expected 0", conflict_cnt3);
    end
    idle(2);
  endtask

  task automatic test_fetch_stream();
    for (int k = 0; k <= 7; k++) begin
      if_req  = (k <= 5);
      if_addr = 8'(k);
      @(negedge clk);
      tests_run++;
      if ({if_gnt, mem_en, mem_we} !== {(k <= 5), (k <= 5), 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL fetch_gnt k=%0d: got %b expected %b", k, {if_gnt, mem_en, mem_we}, {(k <= 5), (k <= 5), 1'b0});
      end
      if (k <= 5) begin
        tests_run++;
        if (mem_addr !== 8'(k)) begin
          tests_failed++;
          $display("[TB] FAIL fetch_addr k=%0d: got %h expected %h", k, mem_addr, 8'(k));
        end
      end
      tests_run++;
      if (if_valid !== (k >= 1 && k <= 6)) begin
        tests_failed++;
        $display("[TB] FAIL fetch_valid k=%0d: got %b expected %b", k, if_valid, (k >= 1 && k <= 6));
      end
      if (k >= 1 && k <= 6) begin
        tests_run++;
        if (mem_rdata !== ref_mem[k-1]) begin
          tests_failed++;
          $display("[TB] FAIL fetch_rdata k=%0d: got %h expected %h", k, mem_rdata, ref_mem[k-1]);
        end
      end
      step();
    end
    idle(1);
  endtask

  task automatic test_write_priority();
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'hff; d_wdata = 16'h0d3d; if_req = 1'b1; if_addr = 8'h10;
    @(negedge clk);
    tests_run++;
    if ({d_gnt, if_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 8'hff, 16'h0d3d}) begin
      tests_failed++;
      $display("[TB] FAIL write_issue: got %h expected %h",
               {d_gnt, if_gnt, mem_en, mem_we, mem_addr, mem_wdata}, {4'b1011, 8'hff, 16'h0d3d});
    end
    ref_mem[8'hff] = 16'h0d3d;
    step();
    d_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({d_valid, if_gnt, mem_we, mem_addr} !== {3'b110, 8'h10}) begin
      tests_failed++;
      $display("[TB] FAIL write_done_fetch: got %h expected %h", {d_valid, if_gnt, mem_we, mem_addr}, {3'b110, 8'h10});
    end
    step();
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 8'hff;
    @(negedge clk);
    tests_run++;
    if ({if_valid, d_valid, d_gnt, mem_rdata} !== {3'b101, ref_mem[8'h10]}) begin
      tests_failed++;
      $display("[TB] FAIL fetch_then_read: got %h expected %h", {if_valid, d_valid, d_gnt, mem_rdata}, {3'b101, ref_mem[8'h10]});
    end
    step();
    d_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({d_valid, mem_rdata} !== {1'b1, 16'h0d3d}) begin
      tests_failed++;
      $display("[TB] FAIL readback_ff: got %h expected %h", {d_valid, mem_rdata}, {1'b1, 16'h0d3d});
    end
    idle(2);
  endtask

  task automatic test_starvation();
    logic [1:0] exp_g;
    if_req = 1'b1; if_addr = 8'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    for (int k = 0; k < 8; k++) begin
      exp_g = (k % 4 == 3) ? 2'b10 : 2'b01;
      @(negedge clk);
      tests_run++;
      if ({if_gnt, d_gnt} !== exp_g) begin
        tests_failed++;
        $display("[TB] FAIL starvation k=%0d: got %b expected %b", k, {if_gnt, d_gnt}, exp_g);
      end
      step();
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic exp_dg, exp_ig, exp_dv;
    for (int k = 0; k <= 9; k++) begin
      d_req3 = (k <= 6); d_we3 = 1'b0; d_addr3 = 8'h40 + 8'(k / 3);
      if_req3 = 1'b1; if_addr3 = 8'h50;
      exp_dg = (k % 3 == 0) && (k <= 6);
      exp_ig = (k == 9);
      exp_dv = (k == 3) || (k == 6) || (k == 9);
      @(negedge clk);
      tests_run++;
      if ({d_gnt3, if_gnt3, d_valid3} !== {exp_dg, exp_ig, exp_dv}) begin
        tests_failed++;
        $display("[TB] FAIL b2b k=%0d: got %b expected %b", k, {d_gnt3, if_gnt3, d_valid3}, {exp_dg, exp_ig, exp_dv});
      end
      if (exp_dv) begin
        tests_run++;
        if (mem_rdata3 !== init_val(8'h40 + 8'(k / 3 - 1))) begin
          tests_failed++;
          $display("[TB] FAIL b2b_rdata k=%0d: got %h expected %h", k, mem_rdata3, init_val(8'h40 + 8'(k / 3 - 1)));
        end
      end
      step();
    end
    idle(4);
  endtask

  task automatic test_reset_mid_busy();
    if_req3 = 1'b1; if_addr3 = 8'h60;
    @(negedge clk);
    tests_run++;
    if (if_gnt3 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midrst_first_gnt: got %b expected 1", if_gnt3);
    end
    step();
    if_req3 = 1'b0;
    #2;
    notrst = 1'b0;
    #1;
    tests_run++;
    if ({if_gnt3, if_valid3, d_gnt3, d_valid3, mem_en3, mem_we3, mem_addr3, mem_wdata3} !== 30'h0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_outputs: got %h expected 0",
               {if_gnt3, if_valid3, d_gnt3, d_valid3, mem_en3, mem_we3, mem_addr3, mem_wdata3});
    end
    step();
    notrst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++;
      if ({if_valid3, d_valid3, mem_en3} !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL midrst_no_valid k=%0d: got %b expected 000", k, {if_valid3, d_valid3, mem_en3});
      end
      step();
    end
    if_req3 = 1'b1; if_addr3 = 8'h61;
    @(negedge clk);
    tests_run++;
    if ({if_gnt3, mem_addr3} !== {1'b1, 8'h61}) begin
      tests_failed++;
      $display("[TB] FAIL midrst_regrant: got %h expected %h", {if_gnt3, mem_addr3}, {1'b1, 8'h61});
    end
    step();
    if_req3 = 1'b0;
    step();
    step();
    @(negedge clk);
    tests_run++;
    if ({if_valid3, mem_rdata3} !== {1'b1, init_val(8'h61)}) begin
      tests_failed++;
      $display("[TB] FAIL midrst_fetch_data: got %h expected %h", {if_valid3, mem_rdata3}, {1'b1, init_val(8'h61)});
    end
    idle(3);
  endtask

  // Reference model: data beats fetch unless fetch has been passed over MAX_WAIT issues in a row.
  task automatic test_random();
    int          denials;
    int          conf;
    logic        w_d, w_if, pv_if, pv_d, pv_rd;
    logic [15:0] pv_data, exp_conf;
    logic [7:0]  ea;
    denials = 0; conf = 0; pv_if = 1'b0; pv_d = 1'b0; pv_rd = 1'b0; pv_data = 16'h0;
    if_req = 1'b1; if_addr = 8'($urandom);
    d_req = 1'b1; d_we = 1'($urandom); d_addr = 8'hf0 + 8'($urandom_range(0, 15)); d_wdata = 16'($urandom);
    for (int n = 0; n <= 400; n++) begin
      if (n == 400) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      @(negedge clk);
      w_d  = d_req && !(if_req && denials == MAX_WAIT);
      w_if = if_req && !w_d;
      ea   = w_d ? d_addr : if_addr;
      tests_run++;
      if ({if_gnt, d_gnt, mem_en, mem_we} !== {w_if, w_d, w_if | w_d, w_d & d_we}) begin
        tests_failed++;
        $display("[TB] FAIL rnd_issue n=%0d: got %b expected %b", n, {if_gnt, d_gnt, mem_en, mem_we},
                 {w_if, w_d, w_if | w_d, w_d & d_we});
      end
      if (w_if || w_d) begin
        tests_run++;
        if (mem_addr !== ea || (w_d && d_we && mem_wdata !== d_wdata)) begin
          tests_failed++;
          $display("[TB] FAIL rnd_addr n=%0d: got %h/%h expected %h/%h", n, mem_addr, mem_wdata, ea, d_wdata);
        end
      end
      tests_run++;
      if ({if_valid, d_valid} !== {pv_if, pv_d}) begin
        tests_failed++;
        $display("[TB] FAIL rnd_valid n=%0d: got %b expected %b", n, {if_valid, d_valid}, {pv_if, pv_d});
      end
      if (pv_rd) begin
        tests_run++;
        if (mem_rdata !== pv_data) begin
          tests_failed++;
          $display("[TB] FAIL rnd_rdata n=%0d: got %h expected %h", n, mem_rdata, pv_data);
        end
      end
      if (if_req && d_req) conf++;
      pv_if   = w_if;
      pv_d    = w_d;
      pv_rd   = w_if || (w_d && !d_we);
      pv_data = ref_mem[ea];
      if (w_d && d_we) ref_mem[d_addr] = d_wdata;
      if (!if_req || w_if) denials = 0;
      else if (w_d && denials < MAX_WAIT) denials++;
      step();
      if (w_if || $urandom_range(0, 7) == 0) begin
        if_req = ($urandom_range(0, 3) != 0); if_addr = 8'($urandom);
      end
      if (w_d || $urandom_range(0, 7) == 0) begin
        d_req = 1'($urandom); d_we = 1'($urandom);
        d_addr = 8'hf0 + 8'($urandom_range(0, 15)); d_wdata = 16'($urandom);
      end
    end
`ifdef MEM_ARB_CONFLICT_CNT_EN
    exp_conf = 16'(conf);
`else
    exp_conf = 16'd0;
`endif
    @(negedge clk);
    tests_run++;
    if (conflict_cnt !== exp_conf) begin
      tests_failed++;
      $display("[TB] FAIL rnd_conflict_cnt: got %0d expected %0d", conflict_cnt, exp_conf);
    end
    idle(2);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    test_reset();
    test_conflict();
    test_fetch_stream();
    test_write_priority();
    test_starvation();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
